// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Word indices are carried at full width (adr[31:2]) and masked to the configured depth.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 30;

    // idx is kept at the widest possible index so the type is independent of ADDR_BITS;
    // bits above ADDR_BITS are always zero after word_idx().
    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [WORD_W-1:0] data;
    } wb_entry_t;

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] adr,
                                                  input int unsigned addr_bits);
        logic [IDX_W-1:0] mask;
        mask = IDX_W'((64'(1) << addr_bits) - 64'(1));
        return adr[31:2] & mask;
    endfunction

endpackage

// File: rtl/dmem_write_buffer.sv
// Circular posted-write FIFO with a parallel youngest-match lookup port.
module dmem_write_buffer
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enq,
    input  wb_entry_t         i_enq_entry,
    input  logic              i_deq,
    output wb_entry_t         o_head,
    output logic [CW-1:0]     o_count,
    input  logic [IDX_W-1:0]  i_lkp_idx,
    output logic              o_hit,
    output logic [WORD_W-1:0] o_hit_data
);

    wb_entry_t     r_buf [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_slot;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_enq) - CW'(i_deq);
        end
    end

    // Entry payloads need no reset: validity comes from the pointers and count.
    always_ff @(posedge i_clk) begin
        if (i_enq) r_buf[r_wr_ptr] <= i_enq_entry;
    end

    assign o_head  = r_buf[r_rd_ptr];
    assign o_count = r_count;

    // Walk oldest to youngest so the last matching entry wins.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        w_slot     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_slot = r_rd_ptr + PW'(i);
            if ((CW'(i) < r_count) && (r_buf[w_slot].idx == i_lkp_idx)) begin
                o_hit      = 1'b1;
                o_hit_data = r_buf[w_slot].data;
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word storage behind a posted write buffer, zero-latency reads.
// Optional statistics counters are built when DMEM_STATS_EN is defined.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned WB_DEPTH  = 4,
    localparam int unsigned CW = $clog2(WB_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [31:0]   adr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic [CW-1:0] wb_count,
    output logic          wb_empty,
    output logic          wb_full,
    output logic [31:0]   rd_cnt,
    output logic [31:0]   wr_cnt,
    output logic [31:0]   fwd_cnt
);

    logic [WORD_W-1:0] r_mem [2**ADDR_BITS];

    logic [IDX_W-1:0]  w_idx;
    logic              w_rd;
    logic              w_drain;
    logic              w_hit;
    logic [WORD_W-1:0] w_hit_data;
    wb_entry_t         w_head;
    wb_entry_t         w_enq_entry;
    logic              w_unused;

    assign w_idx       = word_idx(adr, ADDR_BITS);
    assign w_rd        = mem_read & ~mem_write;
    assign w_enq_entry = '{idx: w_idx, data: wdata};
    assign wb_empty    = (wb_count == '0);
    assign wb_full     = (wb_count == CW'(WB_DEPTH));
    assign w_unused    = ^{w_head.idx, adr[1:0]};

    // Storage is single-ported: drain only on idle cycles or when a write finds the buffer full.
    assign w_drain = (~mem_read & ~mem_write & ~wb_empty) | (mem_write & wb_full);

    dmem_write_buffer #(
        .DEPTH (WB_DEPTH)
    ) u_wbuf (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enq       (mem_write),
        .i_enq_entry (w_enq_entry),
        .i_deq       (w_drain),
        .o_head      (w_head),
        .o_count     (wb_count),
        .i_lkp_idx   (w_idx),
        .o_hit       (w_hit),
        .o_hit_data  (w_hit_data)
    );

    always_ff @(posedge clk) begin
        if (w_drain) r_mem[w_head.idx[ADDR_BITS-1:0]] <= w_head.data;
    end

    always_comb begin
        rdata = '0;
        if (w_rd) rdata = w_hit ? w_hit_data : r_mem[w_idx[ADDR_BITS-1:0]];
    end

`ifdef DMEM_STATS_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    logic [31:0] r_fwd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_fwd_cnt <= '0;
        end else begin
            if (w_rd) r_rd_cnt <= r_rd_cnt + 32'd1;
            if (mem_write) r_wr_cnt <= r_wr_cnt + 32'd1;
            if (w_rd && w_hit) r_fwd_cnt <= r_fwd_cnt + 32'd1;
        end
    end

    assign rd_cnt  = r_rd_cnt;
    assign wr_cnt  = r_wr_cnt;
    assign fwd_cnt = r_fwd_cnt;
`else
    assign rd_cnt  = 32'h0;
    assign wr_cnt  = 32'h0;
    assign fwd_cnt = 32'h0;
`endif

endmodule
